// File: rtl/dfe_apb_pkg.sv
// Shared definitions for the DFE coefficient register file: APB FSM states,
// register map offsets that follow the coefficient block, and STATUS layout.
package dfe_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } apb_state_e;

  // Control registers sit directly after the last IIR coefficient, in this order
  localparam int OFS_CIC       = 0;
  localparam int OFS_CTRL      = 1;
  localparam int OFS_OUT_SEL   = 2;
  localparam int OFS_COEFF_SEL = 3;
  localparam int OFS_COMMIT    = 4;
  localparam int OFS_STATUS    = 5;
  localparam int OFS_ID        = 6;

  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_STICKY_BIT  = 1;
  localparam int STATUS_IN_LSB      = 2;

  localparam logic [31:0] ID_VALUE = 32'h0DFE_0002;

  function automatic int reg_base(input int n_tap, input int num_denum, input int n_iir);
    return n_tap + num_denum * n_iir;
  endfunction

  function automatic int iir_addr(input int n_tap, input int num_denum, input int stage, input int k);
    return n_tap + stage * num_denum + k;
  endfunction

endpackage

// File: rtl/apb_slave_fsm.sv
// APB slave protocol engine: SETUP/ACCESS sequencing, read wait states,
// registered PREADY/PSLVERR and the completion strobes for the register core.
module apb_slave_fsm
  import dfe_apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int PDATA_WIDTH = 32,
  parameter int RD_WAIT     = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [ADDR_WIDTH-1:0]  paddr,
  input  logic [PDATA_WIDTH-1:0] pwdata,
  input  logic                   err,
  output logic                   pready,
  output logic                   pslverr,
  output logic                   wr_en,
  output logic                   rd_en,
  output logic [ADDR_WIDTH-1:0]  xfer_addr,
  output logic [PDATA_WIDTH-1:0] xfer_wdata,
  output logic                   xfer_write
);

  localparam int WW = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;

  apb_state_e    state;
  logic [WW-1:0] wait_cnt;
  logic          start;

  assign start = psel & ~penable;

  // Transfer attributes are captured on entry to SETUP so the core can decode
  // the error response before PREADY is raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      xfer_addr  <= '0;
      xfer_wdata <= '0;
      xfer_write <= 1'b0;
    end else begin
      if (start && (state != ST_ACCESS || pready)) begin
        xfer_addr  <= paddr;
        xfer_wdata <= pwdata;
        xfer_write <= pwrite;
      end
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_SETUP;
        end
        ST_SETUP: begin
          if (penable) begin
            state    <= ST_ACCESS;
            wait_cnt <= WW'(RD_WAIT);
            if (xfer_write || RD_WAIT == 0) begin
              pready  <= 1'b1;
              pslverr <= err;
            end
          end else if (!psel) begin
            state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (pready) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            state   <= start ? ST_SETUP : ST_IDLE;
          end else if (wait_cnt <= WW'(1)) begin
            pready  <= 1'b1;
            pslverr <= err;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign wr_en = pready & xfer_write & ~pslverr;
  assign rd_en = pready & ~xfer_write;

endmodule

// File: rtl/apb_coeff_shadow_regfile.sv
// Double-buffered DFE coefficient register file: APB writes fill a shadow bank
// and a committed update is copied to the active bank on the UPDATE_OK strobe.
module apb_coeff_shadow_regfile
  import dfe_apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int PDATA_WIDTH = 32,
  parameter int COEFF_WIDTH = 20,
  parameter int N_TAP       = 72,
  parameter int NUM_DENUM   = 5,
  parameter int N_IIR       = 3,
  parameter int RD_WAIT     = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  PSEL,
  input  logic                                  PENABLE,
  input  logic                                  PWRITE,
  input  logic [ADDR_WIDTH-1:0]                 PADDR,
  input  logic [PDATA_WIDTH-1:0]                PWDATA,
  output logic [PDATA_WIDTH-1:0]                PRDATA,
  output logic                                  PREADY,
  output logic                                  PSLVERR,
  input  logic                                  UPDATE_OK,
  input  logic [2:0]                            STATUS_IN,
  output logic [N_TAP*COEFF_WIDTH-1:0]          FRAC_DECI_OUT,
  output logic                                  FRAC_DECI_VLD,
  output logic [N_IIR*NUM_DENUM*COEFF_WIDTH-1:0] IIR_OUT,
  output logic [N_IIR-1:0]                      IIR_VLD,
  output logic [4:0]                            CIC_R_OUT,
  output logic                                  CIC_R_VLD,
  output logic [4:0]                            CTRL,
  output logic [1:0]                            OUT_SEL,
  output logic [2:0]                            COEFF_SEL
);

  localparam int N_IIR_COEF = N_IIR * NUM_DENUM;
  localparam int BASE       = reg_base(N_TAP, NUM_DENUM, N_IIR);

  localparam logic [ADDR_WIDTH-1:0] A_CIC       = ADDR_WIDTH'(BASE + OFS_CIC);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL      = ADDR_WIDTH'(BASE + OFS_CTRL);
  localparam logic [ADDR_WIDTH-1:0] A_OUT_SEL   = ADDR_WIDTH'(BASE + OFS_OUT_SEL);
  localparam logic [ADDR_WIDTH-1:0] A_COEFF_SEL = ADDR_WIDTH'(BASE + OFS_COEFF_SEL);
  localparam logic [ADDR_WIDTH-1:0] A_COMMIT    = ADDR_WIDTH'(BASE + OFS_COMMIT);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS    = ADDR_WIDTH'(BASE + OFS_STATUS);
  localparam logic [ADDR_WIDTH-1:0] A_ID        = ADDR_WIDTH'(BASE + OFS_ID);

  logic [ADDR_WIDTH-1:0]  xfer_addr;
  logic [PDATA_WIDTH-1:0] xfer_wdata;
  logic                   xfer_write;
  logic                   wr_en;
  logic                   rd_en;
  logic                   err;

  logic signed [COEFF_WIDTH-1:0] frac_sh  [N_TAP];
  logic signed [COEFF_WIDTH-1:0] frac_act [N_TAP];
  logic signed [COEFF_WIDTH-1:0] iir_sh   [N_IIR_COEF];
  logic signed [COEFF_WIDTH-1:0] iir_act  [N_IIR_COEF];
  logic [4:0]                    cic_sh;
  logic                          frac_dirty;
  logic [N_IIR-1:0]              iir_dirty;
  logic                          cic_dirty;
  logic                          pending;
  logic                          sticky_err;
  logic                          commit_fire;

  logic [PDATA_WIDTH-COEFF_WIDTH:0] wtop;
  logic                             sext_ok;
  logic                             is_coeff;
  logic                             unmapped;
  logic signed [COEFF_WIDTH-1:0]    wr_coeff;
  logic [PDATA_WIDTH-1:0]           rdata;

  apb_slave_fsm #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .PDATA_WIDTH (PDATA_WIDTH),
    .RD_WAIT     (RD_WAIT)
  ) u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .psel       (PSEL),
    .penable    (PENABLE),
    .pwrite     (PWRITE),
    .paddr      (PADDR),
    .pwdata     (PWDATA),
    .err        (err),
    .pready     (PREADY),
    .pslverr    (PSLVERR),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .xfer_addr  (xfer_addr),
    .xfer_wdata (xfer_wdata),
    .xfer_write (xfer_write)
  );

  // A coefficient write is legal only if every bit above the coefficient MSB copies it
  assign wtop     = xfer_wdata[PDATA_WIDTH-1:COEFF_WIDTH-1];
  assign sext_ok  = (&wtop) | ~(|wtop);
  assign wr_coeff = xfer_wdata[COEFF_WIDTH-1:0];
  assign is_coeff = xfer_addr < A_CIC;
  assign unmapped = xfer_addr > A_ID;

  assign err = xfer_write
             ? ((is_coeff && !sext_ok) || xfer_addr == A_STATUS || xfer_addr == A_ID || unmapped)
             : (xfer_addr == A_COMMIT || unmapped);

  assign commit_fire = pending & UPDATE_OK;

  // Later assignments in this block win, so a shadow write on a commit edge
  // leaves its group dirty while the copy still takes the pre-edge shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frac_sh       <= '{default: '0};
      frac_act      <= '{default: '0};
      iir_sh        <= '{default: '0};
      iir_act       <= '{default: '0};
      cic_sh        <= '0;
      CIC_R_OUT     <= '0;
      frac_dirty    <= 1'b0;
      iir_dirty     <= '0;
      cic_dirty     <= 1'b0;
      pending       <= 1'b0;
      sticky_err    <= 1'b0;
      FRAC_DECI_VLD <= 1'b0;
      IIR_VLD       <= '0;
      CIC_R_VLD     <= 1'b0;
      CTRL          <= '0;
      OUT_SEL       <= '0;
      COEFF_SEL     <= '0;
    end else begin
      FRAC_DECI_VLD <= 1'b0;
      IIR_VLD       <= '0;
      CIC_R_VLD     <= 1'b0;

      if (commit_fire) begin
        if (frac_dirty) begin
          frac_act      <= frac_sh;
          FRAC_DECI_VLD <= 1'b1;
          frac_dirty    <= 1'b0;
        end
        for (int s = 0; s < N_IIR; s++) begin
          if (iir_dirty[s]) begin
            for (int k = 0; k < NUM_DENUM; k++) iir_act[s*NUM_DENUM+k] <= iir_sh[s*NUM_DENUM+k];
            IIR_VLD[s]   <= 1'b1;
            iir_dirty[s] <= 1'b0;
          end
        end
        if (cic_dirty) begin
          CIC_R_OUT <= cic_sh;
          CIC_R_VLD <= 1'b1;
          cic_dirty <= 1'b0;
        end
        pending <= 1'b0;
      end

      if (wr_en) begin
        for (int i = 0; i < N_TAP; i++) begin
          if (xfer_addr == ADDR_WIDTH'(i)) begin
            frac_sh[i] <= wr_coeff;
            frac_dirty <= 1'b1;
          end
        end
        for (int s = 0; s < N_IIR; s++) begin
          for (int k = 0; k < NUM_DENUM; k++) begin
            if (xfer_addr == ADDR_WIDTH'(iir_addr(N_TAP, NUM_DENUM, s, k))) begin
              iir_sh[s*NUM_DENUM+k] <= wr_coeff;
              iir_dirty[s]          <= 1'b1;
            end
          end
        end
        if (xfer_addr == A_CIC) begin
          cic_sh    <= xfer_wdata[4:0];
          cic_dirty <= 1'b1;
        end
        if (xfer_addr == A_CTRL)      CTRL      <= xfer_wdata[4:0];
        if (xfer_addr == A_OUT_SEL)   OUT_SEL   <= xfer_wdata[1:0];
        if (xfer_addr == A_COEFF_SEL) COEFF_SEL <= xfer_wdata[2:0];
        if (xfer_addr == A_COMMIT)    pending   <= 1'b1;
      end

      if (PREADY && PSLVERR) sticky_err <= 1'b1;
      else if (rd_en && xfer_addr == A_STATUS) sticky_err <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_TAP; i++)
      if (xfer_addr == ADDR_WIDTH'(i)) rdata = PDATA_WIDTH'(frac_sh[i]);
    for (int j = 0; j < N_IIR_COEF; j++)
      if (xfer_addr == ADDR_WIDTH'(N_TAP + j)) rdata = PDATA_WIDTH'(iir_sh[j]);
    if (xfer_addr == A_CIC)       rdata = PDATA_WIDTH'(cic_sh);
    if (xfer_addr == A_CTRL)      rdata = PDATA_WIDTH'(CTRL);
    if (xfer_addr == A_OUT_SEL)   rdata = PDATA_WIDTH'(OUT_SEL);
    if (xfer_addr == A_COEFF_SEL) rdata = PDATA_WIDTH'(COEFF_SEL);
    if (xfer_addr == A_STATUS) begin
      rdata[STATUS_PENDING_BIT]       = pending;
      rdata[STATUS_STICKY_BIT]        = sticky_err;
      rdata[STATUS_IN_LSB +: 3]       = STATUS_IN;
    end
    if (xfer_addr == A_ID)        rdata = PDATA_WIDTH'(ID_VALUE);
  end

  assign PRDATA = rd_en ? rdata : '0;

  always_comb begin
    FRAC_DECI_OUT = '0;
    for (int i = 0; i < N_TAP; i++) FRAC_DECI_OUT[i*COEFF_WIDTH +: COEFF_WIDTH] = frac_act[i];
  end

  always_comb begin
    IIR_OUT = '0;
    for (int j = 0; j < N_IIR_COEF; j++) IIR_OUT[j*COEFF_WIDTH +: COEFF_WIDTH] = iir_act[j];
  end

endmodule

// File: tb/tb_apb_coeff_shadow_regfile.sv
// Directed bench for apb_coeff_shadow_regfile: APB transfers are scored through
// an expectation queue, shadow/active behaviour is checked around UPDATE_OK.
module tb_apb_coeff_shadow_regfile;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int CW = 20;
  localparam int NT = 72;
  localparam int ND = 5;
  localparam int NI = 3;
  localparam int RW = 2;

  localparam logic [AW-1:0] A_IIR0   = 7'd72;
  localparam logic [AW-1:0] A_CIC    = 7'd87;
  localparam logic [AW-1:0] A_CTRL   = 7'd88;
  localparam logic [AW-1:0] A_OUTSEL = 7'd89;
  localparam logic [AW-1:0] A_CSEL   = 7'd90;
  localparam logic [AW-1:0] A_COMMIT = 7'd91;
  localparam logic [AW-1:0] A_STATUS = 7'd92;
  localparam logic [AW-1:0] A_ID     = 7'd93;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                PSEL = 1'b0;
  logic                PENABLE = 1'b0;
  logic                PWRITE = 1'b0;
  logic [AW-1:0]       PADDR = '0;
  logic [DW-1:0]       PWDATA = '0;
  logic [DW-1:0]       PRDATA;
  logic                PREADY;
  logic                PSLVERR;
  logic                UPDATE_OK = 1'b0;
  logic [2:0]          STATUS_IN = 3'b000;
  logic [NT*CW-1:0]    FRAC_DECI_OUT;
  logic                FRAC_DECI_VLD;
  logic [NI*ND*CW-1:0] IIR_OUT;
  logic [NI-1:0]       IIR_VLD;
  logic [4:0]          CIC_R_OUT;
  logic                CIC_R_VLD;
  logic [4:0]          CTRL;
  logic [1:0]          OUT_SEL;
  logic [2:0]          COEFF_SEL;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
    logic        chk_data;
    int          waits;
  } exp_t;

  exp_t sb[$];

  apb_coeff_shadow_regfile #(
    .ADDR_WIDTH  (AW),
    .PDATA_WIDTH (DW),
    .COEFF_WIDTH (CW),
    .N_TAP       (NT),
    .NUM_DENUM   (ND),
    .N_IIR       (NI),
    .RD_WAIT     (RW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PSEL          (PSEL),
    .PENABLE       (PENABLE),
    .PWRITE        (PWRITE),
    .PADDR         (PADDR),
    .PWDATA        (PWDATA),
    .PRDATA        (PRDATA),
    .PREADY        (PREADY),
    .PSLVERR       (PSLVERR),
    .UPDATE_OK     (UPDATE_OK),
    .STATUS_IN     (STATUS_IN),
    .FRAC_DECI_OUT (FRAC_DECI_OUT),
    .FRAC_DECI_VLD (FRAC_DECI_VLD),
    .IIR_OUT       (IIR_OUT),
    .IIR_VLD       (IIR_VLD),
    .CIC_R_OUT     (CIC_R_OUT),
    .CIC_R_VLD     (CIC_R_VLD),
    .CTRL          (CTRL),
    .OUT_SEL       (OUT_SEL),
    .COEFF_SEL     (COEFF_SEL)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One APB transfer; the expectation is queued as the transfer is driven and
  // retired when PREADY is seen. upd raises UPDATE_OK on the completion edge.
  task automatic apply_stimulus(input string tag, input logic wr, input logic [AW-1:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_data,
                                input logic exp_err, input logic upd);
    exp_t e;
    int   n;
    logic [31:0] obs_data;
    logic obs_err;
    sb.push_back('{tag: tag, data: exp_data, err: exp_err, chk_data: !wr, waits: wr ? 1 : RW + 1});
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(negedge clk);
    PENABLE = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!PREADY && n < 20);
    obs_data = PRDATA;
    obs_err  = PSLVERR;
    e = sb.pop_front();
    if (!PREADY) begin
      check_output({e.tag, "_timeout"}, 64'(PREADY), 64'd1);
    end else begin
      check_output({e.tag, "_pslverr"}, 64'(obs_err), 64'(e.err));
      check_output({e.tag, "_cycles"}, 64'(n), 64'(e.waits));
      if (e.chk_data) check_output({e.tag, "_prdata"}, 64'(obs_data), 64'(e.data));
    end
    UPDATE_OK = upd;
    PSEL = 1'b0; PENABLE = 1'b0;
    if (upd) begin
      @(negedge clk);
      UPDATE_OK = 1'b0;
    end
  endtask

  task automatic pulse_update();
    @(negedge clk);
    UPDATE_OK = 1'b1;
    @(negedge clk);
    UPDATE_OK = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(negedge clk);
    check_output("rst_pready", 64'(PREADY), 64'd0);
    check_output("rst_pslverr", 64'(PSLVERR), 64'd0);
    check_output("rst_prdata", 64'(PRDATA), 64'd0);
    check_output("rst_frac_zero", 64'(FRAC_DECI_OUT == '0), 64'd1);
    check_output("rst_iir_zero", 64'(IIR_OUT == '0), 64'd1);
    check_output("rst_vlds", 64'({FRAC_DECI_VLD, IIR_VLD, CIC_R_VLD}), 64'd0);
    check_output("rst_regs", 64'({CIC_R_OUT, CTRL, OUT_SEL, COEFF_SEL}), 64'd0);
    rst_n = 1'b1;

    // Direct register, then a write aborted by reset while PREADY is high
    apply_stimulus("wr_ctrl", 1'b1, A_CTRL, 32'h15, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("ctrl_direct", 64'(CTRL), 64'h15);
    check_output("ctrl_no_vld", 64'({FRAC_DECI_VLD, IIR_VLD, CIC_R_VLD}), 64'd0);

    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 7'd3; PWDATA = 32'h5;
    @(negedge clk);
    PENABLE = 1'b1;
    @(negedge clk);
    check_output("midrst_pready_before", 64'(PREADY), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_output("midrst_pready", 64'(PREADY), 64'd0);
    check_output("midrst_ctrl", 64'(CTRL), 64'd0);
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0; rst_n = 1'b1;
    apply_stimulus("rd_addr3_after_rst", 1'b0, 7'd3, 32'h0, 32'h0, 1'b0, 1'b0);
    apply_stimulus("rd_ctrl_after_rst", 1'b0, A_CTRL, 32'h0, 32'h0, 1'b0, 1'b0);

    // Shadow writes, commit, and the frame-safe copy
    apply_stimulus("wr_tap0", 1'b1, 7'd0, 32'h0007FFFF, 32'h0, 1'b0, 1'b0);
    apply_stimulus("wr_tap2_neg", 1'b1, 7'd2, 32'hFFFFFFFE, 32'h0, 1'b0, 1'b0);
    apply_stimulus("rd_tap0", 1'b0, 7'd0, 32'h0, 32'h0007FFFF, 1'b0, 1'b0);
    apply_stimulus("rd_tap2", 1'b0, 7'd2, 32'h0, 32'hFFFFFFFE, 1'b0, 1'b0);
    check_output("tap0_not_active", 64'(FRAC_DECI_OUT[0 +: CW]), 64'd0);
    apply_stimulus("wr_commit", 1'b1, A_COMMIT, 32'h1, 32'h0, 1'b0, 1'b0);
    apply_stimulus("rd_status_pending", 1'b0, A_STATUS, 32'h0, 32'h1, 1'b0, 1'b0);
    pulse_update();
    check_output("frac_vld_pulse", 64'(FRAC_DECI_VLD), 64'd1);
    check_output("tap0_active", 64'(FRAC_DECI_OUT[0 +: CW]), 64'h7FFFF);
    check_output("tap2_active", 64'(FRAC_DECI_OUT[2*CW +: CW]), 64'hFFFFE);
    check_output("iir_vld_clean", 64'(IIR_VLD), 64'd0);
    check_output("cic_vld_clean", 64'(CIC_R_VLD), 64'd0);
    @(negedge clk);
    check_output("frac_vld_one_cycle", 64'(FRAC_DECI_VLD), 64'd0);
    apply_stimulus("rd_status_committed", 1'b0, A_STATUS, 32'h0, 32'h0, 1'b0, 1'b0);

    // Out-of-range coefficient is rejected and latches the sticky error
    apply_stimulus("wr_tap1_bad", 1'b1, 7'd1, 32'h00080000, 32'h0, 1'b1, 1'b0);
    apply_stimulus("rd_tap1_unchanged", 1'b0, 7'd1, 32'h0, 32'h0, 1'b0, 1'b0);
    apply_stimulus("rd_status_sticky", 1'b0, A_STATUS, 32'h0, 32'h2, 1'b0, 1'b0);
    apply_stimulus("rd_status_cleared", 1'b0, A_STATUS, 32'h0, 32'h0, 1'b0, 1'b0);

    // COMMIT coincident with UPDATE_OK waits for the next strobe
    apply_stimulus("wr_iir0", 1'b1, A_IIR0, 32'h00012345, 32'h0, 1'b0, 1'b0);
    apply_stimulus("rd_iir0_wait", 1'b0, A_IIR0, 32'h0, 32'h00012345, 1'b0, 1'b0);
    apply_stimulus("wr_commit_coincident", 1'b1, A_COMMIT, 32'h1, 32'h0, 1'b0, 1'b1);
    check_output("coincident_no_iir_vld", 64'(IIR_VLD), 64'd0);
    check_output("coincident_iir_inactive", 64'(IIR_OUT[0 +: CW]), 64'd0);
    apply_stimulus("rd_status_still_pending", 1'b0, A_STATUS, 32'h0, 32'h1, 1'b0, 1'b0);
    pulse_update();
    check_output("iir_vld_stage0", 64'(IIR_VLD), 64'b001);
    check_output("iir0_active", 64'(IIR_OUT[0 +: CW]), 64'h12345);
    check_output("frac_vld_clean", 64'(FRAC_DECI_VLD), 64'd0);

    // Shadow write on the commit edge: copy takes old value, group stays dirty
    apply_stimulus("wr_cic_a", 1'b1, A_CIC, 32'h11, 32'h0, 1'b0, 1'b0);
    apply_stimulus("wr_commit_cic", 1'b1, A_COMMIT, 32'h1, 32'h0, 1'b0, 1'b0);
    apply_stimulus("wr_cic_b_on_commit", 1'b1, A_CIC, 32'h05, 32'h0, 1'b0, 1'b1);
    check_output("cic_vld_first", 64'(CIC_R_VLD), 64'd1);
    check_output("cic_old_value", 64'(CIC_R_OUT), 64'h11);
    check_output("cic_iir_vld_clean", 64'(IIR_VLD), 64'd0);
    apply_stimulus("rd_cic_shadow", 1'b0, A_CIC, 32'h0, 32'h05, 1'b0, 1'b0);
    apply_stimulus("wr_commit_cic2", 1'b1, A_COMMIT, 32'h1, 32'h0, 1'b0, 1'b0);
    pulse_update();
    check_output("cic_vld_second", 64'(CIC_R_VLD), 64'd1);
    check_output("cic_new_value", 64'(CIC_R_OUT), 64'h05);

    // Sign-extension boundaries and direct selects
    apply_stimulus("wr_iir1_min", 1'b1, 7'd73, 32'hFFF80000, 32'h0, 1'b0, 1'b0);
    apply_stimulus("rd_iir1_min", 1'b0, 7'd73, 32'h0, 32'hFFF80000, 1'b0, 1'b0);
    apply_stimulus("wr_iir2_mixed", 1'b1, 7'd74, 32'h7FF80000, 32'h0, 1'b1, 1'b0);
    apply_stimulus("wr_outsel", 1'b1, A_OUTSEL, 32'h2, 32'h0, 1'b0, 1'b0);
    apply_stimulus("wr_coeffsel", 1'b1, A_CSEL, 32'h5, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("out_sel_direct", 64'(OUT_SEL), 64'h2);
    check_output("coeff_sel_direct", 64'(COEFF_SEL), 64'h5);

    // Error responses and read-only registers
    apply_stimulus("rd_unmapped", 1'b0, 7'h7F, 32'h0, 32'h0, 1'b1, 1'b0);
    apply_stimulus("rd_id", 1'b0, A_ID, 32'h0, 32'h0DFE0002, 1'b0, 1'b0);
    apply_stimulus("rd_commit", 1'b0, A_COMMIT, 32'h0, 32'h0, 1'b1, 1'b0);
    apply_stimulus("wr_id", 1'b1, A_ID, 32'h1234, 32'h0, 1'b1, 1'b0);
    apply_stimulus("wr_unmapped", 1'b1, 7'h7F, 32'h1, 32'h0, 1'b1, 1'b0);
    apply_stimulus("rd_id_unchanged", 1'b0, A_ID, 32'h0, 32'h0DFE0002, 1'b0, 1'b0);
    STATUS_IN = 3'b101;
    apply_stimulus("rd_status_in_sticky", 1'b0, A_STATUS, 32'h0, 32'h16, 1'b0, 1'b0);
    apply_stimulus("rd_status_in_only", 1'b0, A_STATUS, 32'h0, 32'h14, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
